// File: rtl/hc_pkg.sv
// Shared constants, FSM state type and the Hamming(7,4) encoder used by the scrub controller.
// Codeword bit k holds position k+1: {d4,d3,d2,p4,d1,p2,p1}.
package hc_pkg;

    localparam int CW_WD   = 7;
    localparam int DATA_WD = 4;
    localparam int CHK_WD  = 3;

    typedef enum logic [1:0] {
        IDLE,
        HOST_RD,
        SCRUB
    } state_e;

    function automatic logic [CW_WD-1:0] hc_encode(input logic [DATA_WD-1:0] d);
        logic p1;
        logic p2;
        logic p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

endpackage

// File: rtl/hc_dec7.sv
// Hamming(7,4) decoder: computes the syndrome, flips the indicated position and extracts data.
module hc_dec7
    import hc_pkg::*;
(
    input  logic [CW_WD-1:0]   cw_i,
    output logic [CHK_WD-1:0]  syn_o,
    output logic               err_o,
    output logic [CW_WD-1:0]   cor_o,
    output logic [DATA_WD-1:0] data_o
);

    logic [CHK_WD-1:0] syn;
    logic [CW_WD-1:0]  flipMask;
    logic [CW_WD-1:0]  cor;

    // Each syndrome bit checks the positions whose index has that bit set.
    assign syn[0] = cw_i[0] ^ cw_i[2] ^ cw_i[4] ^ cw_i[6];
    assign syn[1] = cw_i[1] ^ cw_i[2] ^ cw_i[5] ^ cw_i[6];
    assign syn[2] = cw_i[3] ^ cw_i[4] ^ cw_i[5] ^ cw_i[6];

    assign flipMask = (syn != '0) ? (CW_WD'(1) << (syn - CHK_WD'(1))) : '0;
    assign cor      = cw_i ^ flipMask;

    assign syn_o  = syn;
    assign err_o  = (syn != '0);
    assign cor_o  = cor;
    assign data_o = {cor[6], cor[5], cor[4], cor[2]};

endmodule

// File: rtl/hc_ecc_scrub_ctrl.sv
// ECC-protected codeword store: encoded host writes, corrected host reads with writeback,
// and a periodic background scrubber sharing one decoder.
module hc_ecc_scrub_ctrl
    import hc_pkg::*;
#(
    parameter  int DEPTH          = 16,
    parameter  int SCRUB_INTERVAL = 256,
    parameter  int ERR_CNT_WD     = 8,
    localparam int AW             = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [AW-1:0]         i_req_addr,
    input  logic [DATA_WD-1:0]    i_req_wdata,
    input  logic [2:0]            i_inj_pos,
    output logic                  o_rsp_valid,
    output logic [DATA_WD-1:0]    o_rsp_rdata,
    output logic                  o_rsp_err,
    input  logic                  i_scrub_en,
    output logic                  o_scrub_busy,
    input  logic                  i_clr_cnt,
    output logic [ERR_CNT_WD-1:0] o_corr_cnt
);

    localparam int ICW = $clog2(SCRUB_INTERVAL);

    state_e                state_q, state_d;
    logic [CW_WD-1:0]      mem_q [DEPTH];
    logic [AW-1:0]         rdAddr_q, rdAddr_d;
    logic [AW-1:0]         ptr_q, ptr_d;
    logic [ICW-1:0]        intCnt_q, intCnt_d;
    logic                  pending_q, pending_d;
    logic [ERR_CNT_WD-1:0] corrCnt_q, corrCnt_d;
    logic                  rspValid_q, rspValid_d;
    logic [DATA_WD-1:0]    rspData_q, rspData_d;
    logic                  rspErr_q, rspErr_d;

    logic                  memWe;
    logic [AW-1:0]         memWaddr;
    logic [CW_WD-1:0]      memWdata;
    logic                  incCnt;
    logic                  scrubStart;
    logic                  termCount;
    logic [CW_WD-1:0]      injMask;

    logic [CW_WD-1:0]      decIn;
    logic [CHK_WD-1:0]     decSyn;
    logic                  decErr;
    logic [CW_WD-1:0]      decCor;
    logic [DATA_WD-1:0]    decData;

    assign decIn = (state_q == SCRUB) ? mem_q[ptr_q] : mem_q[rdAddr_q];

    hc_dec7 uDec (
        .cw_i   (decIn),
        .syn_o  (decSyn),
        .err_o  (decErr),
        .cor_o  (decCor),
        .data_o (decData)
    );

    assign injMask = (i_inj_pos != 3'd0) ? (CW_WD'(1) << (i_inj_pos - 3'd1)) : '0;

    // Main FSM: a pending scrub always wins over a host request in IDLE.
    always_comb begin
        state_d    = state_q;
        rdAddr_d   = rdAddr_q;
        ptr_d      = ptr_q;
        rspValid_d = 1'b0;
        rspData_d  = rspData_q;
        rspErr_d   = rspErr_q;
        memWe      = 1'b0;
        memWaddr   = rdAddr_q;
        memWdata   = decCor;
        incCnt     = 1'b0;
        scrubStart = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pending_q) begin
                    scrubStart = 1'b1;
                    state_d    = SCRUB;
                end else if (i_req_valid) begin
                    if (i_req_we) begin
                        memWe    = 1'b1;
                        memWaddr = i_req_addr;
                        memWdata = hc_encode(i_req_wdata) ^ injMask;
                    end else begin
                        rdAddr_d = i_req_addr;
                        state_d  = HOST_RD;
                    end
                end
            end
            HOST_RD: begin
                rspValid_d = 1'b1;
                rspData_d  = decData;
                rspErr_d   = (decSyn != '0);
                if (decErr) begin
                    memWe    = 1'b1;
                    memWaddr = rdAddr_q;
                    incCnt   = 1'b1;
                end
                state_d = IDLE;
            end
            SCRUB: begin
                if (decErr) begin
                    memWe    = 1'b1;
                    memWaddr = ptr_q;
                    incCnt   = 1'b1;
                end
                ptr_d   = ptr_q + AW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A terminal count while a scrub is already pending simply merges into it.
    always_comb begin
        termCount = i_scrub_en && (intCnt_q == ICW'(SCRUB_INTERVAL - 1));
        intCnt_d  = intCnt_q;
        if (i_scrub_en) begin
            intCnt_d = termCount ? '0 : intCnt_q + ICW'(1);
        end
        pending_d = termCount ? 1'b1 : (scrubStart ? 1'b0 : pending_q);
        corrCnt_d = corrCnt_q;
        if (i_clr_cnt) begin
            corrCnt_d = '0;
        end else if (incCnt && (corrCnt_q != '1)) begin
            corrCnt_d = corrCnt_q + ERR_CNT_WD'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            rdAddr_q   <= '0;
            ptr_q      <= '0;
            intCnt_q   <= '0;
            pending_q  <= 1'b0;
            corrCnt_q  <= '0;
            rspValid_q <= 1'b0;
            rspData_q  <= '0;
            rspErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdAddr_q   <= rdAddr_d;
            ptr_q      <= ptr_d;
            intCnt_q   <= intCnt_d;
            pending_q  <= pending_d;
            corrCnt_q  <= corrCnt_d;
            rspValid_q <= rspValid_d;
            rspData_q  <= rspData_d;
            rspErr_q   <= rspErr_d;
        end
    end

    // All-zero is the valid codeword for data 0, so reset leaves the store consistent.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (memWe) begin
            mem_q[memWaddr] <= memWdata;
        end
    end

    assign o_req_ready  = (state_q == IDLE) && !pending_q;
    assign o_scrub_busy = (state_q == SCRUB);
    assign o_rsp_valid  = rspValid_q;
    assign o_rsp_rdata  = rspData_q;
    assign o_rsp_err    = rspErr_q;
    assign o_corr_cnt   = corrCnt_q;

endmodule

// File: tb/tb_hc_ecc_scrub_ctrl.sv
// Directed self-checking bench for hc_ecc_scrub_ctrl (DEPTH=4, SCRUB_INTERVAL=4, 3-bit counter).
module tb_hc_ecc_scrub_ctrl;

    logic       clk;
    logic       rstN;
    logic       reqValid;
    logic       reqReady;
    logic       reqWe;
    logic [1:0] reqAddr;
    logic [3:0] reqWdata;
    logic [2:0] injPos;
    logic       rspValid;
    logic [3:0] rspRdata;
    logic       rspErr;
    logic       scrubEn;
    logic       scrubBusy;
    logic       clrCnt;
    logic [2:0] corrCnt;

    int checks   = 0;
    int failures = 0;

    hc_ecc_scrub_ctrl #(
        .DEPTH          (4),
        .SCRUB_INTERVAL (4),
        .ERR_CNT_WD     (3)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_req_valid  (reqValid),
        .o_req_ready  (reqReady),
        .i_req_we     (reqWe),
        .i_req_addr   (reqAddr),
        .i_req_wdata  (reqWdata),
        .i_inj_pos    (injPos),
        .o_rsp_valid  (rspValid),
        .o_rsp_rdata  (rspRdata),
        .o_rsp_err    (rspErr),
        .i_scrub_en   (scrubEn),
        .o_scrub_busy (scrubBusy),
        .i_clr_cnt    (clrCnt),
        .o_corr_cnt   (corrCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic doWrite(input logic [1:0] addr, input logic [3:0] data, input logic [2:0] inj);
        @(negedge clk);
        reqValid = 1'b1;
        reqWe    = 1'b1;
        reqAddr  = addr;
        reqWdata = data;
        injPos   = inj;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        reqWe    = 1'b0;
        injPos   = 3'd0;
    endtask

    // Present a read, wait (bounded) for acceptance, then check the two-cycle response timing.
    task automatic doRead(input logic [1:0] addr, input logic [3:0] expData, input logic expErr,
                          input string tag, input logic clrInRd);
        int n;
        n = 0;
        @(negedge clk);
        reqValid = 1'b1;
        reqWe    = 1'b0;
        reqAddr  = addr;
        while (!reqReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_ready"}, 32'(reqReady), 32'd1);
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        clrCnt   = clrInRd;
        @(negedge clk);
        checkOutput({tag, "_rspEarly"}, 32'(rspValid), 32'd0);
        @(posedge clk);
        #1;
        clrCnt = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_rspValid"}, 32'(rspValid), 32'd1);
        checkOutput({tag, "_rdata"}, 32'(rspRdata), 32'(expData));
        checkOutput({tag, "_err"}, 32'(rspErr), 32'(expErr));
    endtask

    task automatic pulseClr();
        @(negedge clk);
        clrCnt = 1'b1;
        @(posedge clk);
        #1;
        clrCnt = 1'b0;
    endtask

    initial begin
        int busyCount;
        logic [3:0] scrubData [4];

        rstN     = 1'b0;
        reqValid = 1'b0;
        reqWe    = 1'b0;
        reqAddr  = '0;
        reqWdata = '0;
        injPos   = '0;
        scrubEn  = 1'b0;
        clrCnt   = 1'b0;
        scrubData[0] = 4'h1;
        scrubData[1] = 4'h5;
        scrubData[2] = 4'hA;
        scrubData[3] = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;

        @(negedge clk);
        checkOutput("rst_ready", 32'(reqReady), 32'd1);
        checkOutput("rst_rspValid", 32'(rspValid), 32'd0);
        checkOutput("rst_rdata", 32'(rspRdata), 32'd0);
        checkOutput("rst_err", 32'(rspErr), 32'd0);
        checkOutput("rst_busy", 32'(scrubBusy), 32'd0);
        checkOutput("rst_cnt", 32'(corrCnt), 32'd0);

        doRead(2'd3, 4'h0, 1'b0, "rdReset", 1'b0);
        @(negedge clk);
        checkOutput("rdReset_pulseEnds", 32'(rspValid), 32'd0);
        checkOutput("rdReset_rdataHold", 32'(rspRdata), 32'd0);

        doWrite(2'd1, 4'hB, 3'd0);
        doRead(2'd1, 4'hB, 1'b0, "rdClean", 1'b0);

        doWrite(2'd2, 4'h6, 3'd5);
        doRead(2'd2, 4'h6, 1'b1, "rdInj", 1'b0);
        checkOutput("rdInj_cnt", 32'(corrCnt), 32'd1);
        doRead(2'd2, 4'h6, 1'b0, "rdWriteback", 1'b0);
        checkOutput("rdWriteback_cnt", 32'(corrCnt), 32'd1);

        pulseClr();
        @(negedge clk);
        checkOutput("clr_cnt", 32'(corrCnt), 32'd0);

        for (int i = 0; i < 4; i++) begin
            doWrite(2'(i), scrubData[i], 3'(i + 1));
        end
        busyCount = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (scrubBusy) busyCount++;
            if (i == 0) scrubEn = 1'b1;
            if (i == 16) scrubEn = 1'b0;
        end
        checkOutput("scrub_pulses", 32'(busyCount), 32'd4);
        checkOutput("scrub_cnt", 32'(corrCnt), 32'd4);
        for (int i = 0; i < 4; i++) begin
            doRead(2'(i), scrubData[i], 1'b0, $sformatf("scrubRd%0d", i), 1'b0);
        end
        checkOutput("scrubRd_cnt", 32'(corrCnt), 32'd4);

        // Hold a read request across a pending scrub: it must wait for SCRUB to finish.
        doWrite(2'd0, 4'h3, 3'd7);
        @(negedge clk);
        scrubEn = 1'b1;
        repeat (4) @(negedge clk);
        scrubEn  = 1'b0;
        reqValid = 1'b1;
        reqWe    = 1'b0;
        reqAddr  = 2'd0;
        checkOutput("pend_readyLow", 32'(reqReady), 32'd0);
        checkOutput("pend_notBusy", 32'(scrubBusy), 32'd0);
        @(negedge clk);
        checkOutput("pend_busy", 32'(scrubBusy), 32'd1);
        checkOutput("pend_readyLowScrub", 32'(reqReady), 32'd0);
        @(negedge clk);
        checkOutput("pend_readyBack", 32'(reqReady), 32'd1);
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        @(negedge clk);
        checkOutput("pend_rspEarly", 32'(rspValid), 32'd0);
        @(negedge clk);
        checkOutput("pend_rspValid", 32'(rspValid), 32'd1);
        checkOutput("pend_rdata", 32'(rspRdata), 32'h3);
        checkOutput("pend_err", 32'(rspErr), 32'd0);
        checkOutput("pend_cnt", 32'(corrCnt), 32'd5);

        pulseClr();
        for (int i = 0; i < 8; i++) begin
            doWrite(2'd1, 4'(i + 2), 3'((i % 7) + 1));
            doRead(2'd1, 4'(i + 2), 1'b1, $sformatf("sat%0d", i), 1'b0);
        end
        checkOutput("sat_cnt", 32'(corrCnt), 32'd7);

        doWrite(2'd2, 4'hC, 3'd6);
        doRead(2'd2, 4'hC, 1'b1, "clrRd", 1'b1);
        checkOutput("clrRd_cnt", 32'(corrCnt), 32'd0);

        doWrite(2'd3, 4'h9, 3'd2);
        @(negedge clk);
        reqValid = 1'b1;
        reqWe    = 1'b0;
        reqAddr  = 2'd3;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        rstN     = 1'b0;
        @(posedge clk);
        #1;
        rstN = 1'b1;
        busyCount = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rspValid) busyCount++;
        end
        checkOutput("rstRd_noRsp", 32'(busyCount), 32'd0);
        checkOutput("rstRd_cnt", 32'(corrCnt), 32'd0);
        checkOutput("rstRd_rdata", 32'(rspRdata), 32'd0);
        doRead(2'd3, 4'h0, 1'b0, "rstRd_memCleared", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
